// File: rtl/mxv_pkg.sv
// mxv_pkg: shared types, constants and helpers for the MxV sequencer.
//   seq_state_t - sequencer FSM state encoding
//   MAX_N       - largest supported matrix dimension (rows = cols = N)
//   DATA_W      - unsigned element width
//   ACC_W       - accumulator / result width (>= 2*DATA_W + clog2(MAX_N))
//   n_valid()   - 1 when 1 <= n <= MAX_N
package mxv_pkg;

  localparam int MAX_N  = 8;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int IDX_W  = $clog2(MAX_N);
  localparam int N_W    = 4;  // width of the n_size port and of the element counters

  typedef enum logic [2:0] {
    S_IDLE,
    S_VLOAD,
    S_ROW,
    S_DRAIN,
    S_EMIT,
    S_FIN
  } seq_state_t;

  function automatic logic n_valid(input logic [N_W-1:0] n);
    return (n >= N_W'(1)) && (n <= N_W'(MAX_N));
  endfunction

endpackage

// File: rtl/mxv_mac_unit.sv
// mxv_mac_unit: registered unsigned multiply-accumulate.
//   clk, rst - clock, synchronous active-high reset
//   clr      - synchronous clear of the accumulator (wins over en)
//   en       - add a*b into the accumulator this cycle
//   a, b     - DATA_W-bit unsigned operands
//   acc      - ACC_W-bit running sum, wraps modulo 2^ACC_W
module mxv_mac_unit
  import mxv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;

  assign prod = a * b;

  // NOTE: registers are always written with non-blocking (<=) so every flop
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/mxv_sequencer.sv
// mxv_sequencer: computes one matrix-by-vector product per start pulse.
// Loads N vector elements into a register file, then for each row r pops N
// elements from row FIFO r, multiply-accumulates them against the vector and
// hands the row sum to the TX side over valid/ready.
//   clk, rst                  - clock, synchronous active-high reset
//   start, n_size             - begin a product of dimension n_size
//   vec_empty/vec_data/vec_pop - vector FIFO (data valid the cycle after pop)
//   row_sel                   - index of the row FIFO being read
//   row_empty/row_data/row_pop - selected row FIFO (data valid after pop)
//   result_valid/data/ready   - row sum handshake towards the TX framer
//   busy, done, err           - status: running, finished pulse, bad n_size pulse
module mxv_sequencer
  import mxv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    n_size,
  input  logic              vec_empty,
  input  logic [DATA_W-1:0] vec_data,
  output logic              vec_pop,
  output logic [IDX_W-1:0]  row_sel,
  input  logic              row_empty,
  input  logic [DATA_W-1:0] row_data,
  output logic              row_pop,
  output logic              result_valid,
  output logic [ACC_W-1:0]  result_data,
  input  logic              result_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  seq_state_t        state, state_next;
  logic [N_W-1:0]    n_reg;
  logic [N_W-1:0]    pop_cnt;    // pops issued in the current load/row
  logic [N_W-1:0]    col;        // vreg write index (VLOAD) / read index (ROW)
  logic [IDX_W-1:0]  row_q;
  logic              vec_pop_d;  // vec_data is valid this cycle
  logic              row_pop_d;  // row_data is valid this cycle
  logic [DATA_W-1:0] vreg [MAX_N];
  logic              last_row;
  logic              mac_clr;
  logic [ACC_W-1:0]  acc;

  assign last_row = (N_W'(row_q) == n_reg - N_W'(1));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    vec_pop    = 1'b0;
    row_pop    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && n_valid(n_size)) state_next = S_VLOAD;
      end
      S_VLOAD: begin
        vec_pop = !vec_empty && (pop_cnt < n_reg);
        if (vec_pop_d && (col == n_reg - N_W'(1))) state_next = S_ROW;
      end
      S_ROW: begin
        row_pop = !row_empty && (pop_cnt < n_reg);
        if (row_pop && (pop_cnt == n_reg - N_W'(1))) state_next = S_DRAIN;
      end
      // The last popped element arrives this cycle; let it accumulate.
      S_DRAIN: state_next = S_EMIT;
      S_EMIT: begin
        if (result_ready) state_next = last_row ? S_FIN : S_ROW;
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Accumulator starts each row from zero: on entry from VLOAD and on each
  // accepted result that is followed by another row.
  assign mac_clr = ((state == S_VLOAD) && (state_next == S_ROW)) ||
                   ((state == S_EMIT) && result_ready && !last_row);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      n_reg     <= '0;
      pop_cnt   <= '0;
      col       <= '0;
      row_q     <= '0;
      vec_pop_d <= 1'b0;
      row_pop_d <= 1'b0;
      err       <= 1'b0;
      // NOTE: the vector store is a handful of flops, not a RAM, so it is
      // reset explicitly to give a defined all-zero state after rst.
      for (int i = 0; i < MAX_N; i++) vreg[i] <= '0;
    end else begin
      state     <= state_next;
      vec_pop_d <= vec_pop;
      row_pop_d <= row_pop;
      err       <= (state == S_IDLE) && start && !n_valid(n_size);
      case (state)
        S_IDLE: begin
          if (start && n_valid(n_size)) begin
            n_reg   <= n_size;
            pop_cnt <= '0;
            col     <= '0;
            row_q   <= '0;
          end
        end
        S_VLOAD: begin
          if (vec_pop) pop_cnt <= pop_cnt + N_W'(1);
          if (vec_pop_d) begin
            vreg[col[IDX_W-1:0]] <= vec_data;
            col                  <= col + N_W'(1);
          end
          if (state_next == S_ROW) begin
            pop_cnt <= '0;
            col     <= '0;
          end
        end
        S_ROW: begin
          if (row_pop)   pop_cnt <= pop_cnt + N_W'(1);
          if (row_pop_d) col     <= col + N_W'(1);
        end
        S_DRAIN: begin
          if (row_pop_d) col <= col + N_W'(1);
        end
        S_EMIT: begin
          if (result_ready && !last_row) begin
            row_q   <= row_q + IDX_W'(1);
            pop_cnt <= '0;
            col     <= '0;
          end
        end
        S_FIN:   row_q <= '0;
        default: ;
      endcase
    end
  end

  mxv_mac_unit u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (row_pop_d),
    .a   (row_data),
    .b   (vreg[col[IDX_W-1:0]]),
    .acc (acc)
  );

  assign row_sel      = row_q;
  assign result_valid = (state == S_EMIT);
  assign result_data  = acc;
  assign busy         = (state != S_IDLE) && (state != S_FIN);
  assign done         = (state == S_FIN);

endmodule

// File: tb/tb_mxv_sequencer.sv
// tb_mxv_sequencer: directed self-checking bench for mxv_sequencer.
// Behavioural vector/row FIFOs feed the DUT; a monitor records accepted
// results, done/err pulses, pop counts and pops issued while empty.
module tb_mxv_sequencer;
  import mxv_pkg::*;

  logic              clk;
  logic              rst;
  logic              start;
  logic [N_W-1:0]    n_size;
  logic              vec_empty;
  logic [DATA_W-1:0] vec_data = '0;
  logic              vec_pop;
  logic [IDX_W-1:0]  row_sel;
  logic              row_empty;
  logic [DATA_W-1:0] row_data = '0;
  logic              row_pop;
  logic              result_valid;
  logic [ACC_W-1:0]  result_data;
  logic              result_ready;
  logic              busy;
  logic              done;
  logic              err;

  mxv_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .n_size       (n_size),
    .vec_empty    (vec_empty),
    .vec_data     (vec_data),
    .vec_pop      (vec_pop),
    .row_sel      (row_sel),
    .row_empty    (row_empty),
    .row_data     (row_data),
    .row_pop      (row_pop),
    .result_valid (result_valid),
    .result_data  (result_data),
    .result_ready (result_ready),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models: write pointers owned by the initial block, read pointers
  // owned by the clocked model.
  logic [DATA_W-1:0] vmem [256];
  logic [DATA_W-1:0] rmem [MAX_N][64];
  int vwr = 0;
  int vrd = 0;
  int rwr [MAX_N];
  int rrd [MAX_N];
  logic vec_block, row_block, flush;

  assign vec_empty = vec_block || (vwr == vrd);
  assign row_empty = row_block || (rwr[row_sel] == rrd[row_sel]);

  // Monitor state
  int checks = 0;
  int failures = 0;
  int pop_viol = 0;
  int vpops = 0;
  int rpops = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int res_n = 0;
  logic [ACC_W-1:0] res_mem [64];

  always @(posedge clk) begin
    if (flush) begin
      vrd <= vwr;
      for (int i = 0; i < MAX_N; i++) rrd[i] <= rwr[i];
    end else begin
      if (vec_pop) begin
        vpops <= vpops + 1;
        if (vec_empty) pop_viol <= pop_viol + 1;
        else begin
          vec_data <= vmem[vrd];
          vrd      <= vrd + 1;
        end
      end
      if (row_pop) begin
        rpops <= rpops + 1;
        if (row_empty) pop_viol <= pop_viol + 1;
        else begin
          row_data     <= rmem[row_sel][rrd[row_sel]];
          rrd[row_sel] <= rrd[row_sel] + 1;
        end
      end
    end
    if (result_valid && result_ready) begin
      res_mem[res_n] <= result_data;
      res_n          <= res_n + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_vec(input int v);
    vmem[vwr] = DATA_W'(v);
    vwr++;
  endtask

  task automatic push_row(input int r, input int v);
    rmem[r][rwr[r]] = DATA_W'(v);
    rwr[r]++;
  endtask

  task automatic do_start(input int n);
    start  = 1'b1;
    n_size = N_W'(n);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    int k = 0;
    while (done_cnt == base && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, (done_cnt != base), 1);
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, done_cnt - base, 1);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (!result_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid_seen"}, result_valid, 1);
  endtask

  int rb, db, eb, vb, rpb, k;
  int exp3 [3] = '{6, 15, 24};

  initial begin
    for (int i = 0; i < MAX_N; i++) rwr[i] = 0;
    rst = 1'b1; start = 1'b0; n_size = '0; result_ready = 1'b1;
    vec_block = 1'b0; row_block = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_vec_pop", vec_pop, 0);
    check("rst_row_pop", row_pop, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_data", result_data, 0);
    check("rst_row_sel", row_sel, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: N=2, vector [5,6], rows [1,2],[3,4] -> 17, 39
    push_vec(5); push_vec(6);
    push_row(0, 1); push_row(0, 2); push_row(1, 3); push_row(1, 4);
    rb = res_n; db = done_cnt;
    do_start(2);
    check("t1_busy_after_start", busy, 1);
    k = 0;
    while (!result_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t1_first_latency", k, 6);
    wait_done("t1", db, 200);
    check("t1_count", res_n - rb, 2);
    check("t1_row0", res_mem[rb], 17);
    check("t1_row1", res_mem[rb+1], 39);
    check("t1_row_sel_back", row_sel, 0);

    // 2: N=8, all 0xFF -> eight results of 520200
    for (int i = 0; i < 8; i++) push_vec(255);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) push_row(r, 255);
    rb = res_n; db = done_cnt;
    do_start(8);
    wait_done("t2", db, 500);
    check("t2_count", res_n - rb, 8);
    for (int i = 0; i < 8; i++) check("t2_row", res_mem[rb+i], 520200);

    // 3: N=3, backpressure 5 cycles per result -> 6, 15, 24 held stable
    push_vec(1); push_vec(1); push_vec(1);
    push_row(0, 1); push_row(0, 2); push_row(0, 3);
    push_row(1, 4); push_row(1, 5); push_row(1, 6);
    push_row(2, 7); push_row(2, 8); push_row(2, 9);
    rb = res_n; db = done_cnt;
    result_ready = 1'b0;
    do_start(3);
    for (int i = 0; i < 3; i++) begin
      wait_valid("t3", 100);
      for (int j = 0; j < 5; j++) begin
        check("t3_hold_valid", result_valid, 1);
        check("t3_hold_data", result_data, exp3[i]);
        @(negedge clk);
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
    end
    wait_done("t3", db, 100);
    result_ready = 1'b1;
    check("t3_count", res_n - rb, 3);
    for (int i = 0; i < 3; i++) check("t3_row", res_mem[rb+i], exp3[i]);

    // 4: N=2, vector FIFO empty 4 cycles, row FIFO toggling -> 69, 37
    push_vec(3); push_vec(7);
    push_row(0, 2); push_row(0, 9); push_row(1, 10); push_row(1, 1);
    rb = res_n; db = done_cnt; vb = vpops;
    vec_block = 1'b1;
    do_start(2);
    repeat (4) @(negedge clk);
    check("t4_no_vpop_while_empty", vpops - vb, 0);
    vec_block = 1'b0;
    k = 0;
    while (done_cnt == db && k < 200) begin
      row_block = ~row_block;
      @(negedge clk);
      k++;
    end
    row_block = 1'b0;
    wait_done("t4", db, 10);
    check("t4_count", res_n - rb, 2);
    check("t4_row0", res_mem[rb], 69);
    check("t4_row1", res_mem[rb+1], 37);
    check("t4_pop_while_empty", pop_viol, 0);

    // 5: bad n_size -> err pulses, no activity; start while busy ignored
    eb = err_cnt; vb = vpops; rpb = rpops;
    do_start(0);
    check("t5_err_n0", err, 1);
    check("t5_busy_n0", busy, 0);
    @(negedge clk);
    check("t5_err_one_cycle", err, 0);
    do_start(9);
    check("t5_err_n9", err, 1);
    check("t5_busy_n9", busy, 0);
    repeat (3) @(negedge clk);
    check("t5_err_count", err_cnt - eb, 2);
    check("t5_no_vpops", vpops - vb, 0);
    check("t5_no_rpops", rpops - rpb, 0);
    push_vec(1); push_vec(2);
    push_row(0, 3); push_row(0, 4); push_row(1, 5); push_row(1, 6);
    rb = res_n; db = done_cnt; eb = err_cnt;
    do_start(2);
    repeat (2) @(negedge clk);
    do_start(0);
    do_start(3);
    wait_done("t5", db, 200);
    check("t5_busy_start_no_err", err_cnt - eb, 0);
    check("t5_count", res_n - rb, 2);
    check("t5_row0", res_mem[rb], 11);
    check("t5_row1", res_mem[rb+1], 17);

    // 6: reset mid-ROW, then a clean product -> 23, 33
    for (int i = 0; i < 3; i++) push_vec(1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) push_row(r, 1);
    db = done_cnt;
    do_start(3);
    k = 0;
    while (!row_pop && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t6_reached_row", row_pop, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_vec_pop", vec_pop, 0);
    check("t6_row_pop", row_pop, 0);
    check("t6_result_valid", result_valid, 0);
    check("t6_result_data", result_data, 0);
    check("t6_row_sel", row_sel, 0);
    check("t6_done", done, 0);
    check("t6_err", err, 0);
    rst = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_no_done", done_cnt - db, 0);
    check("t6_idle_busy", busy, 0);
    push_vec(2); push_vec(3);
    push_row(0, 4); push_row(0, 5); push_row(1, 6); push_row(1, 7);
    rb = res_n; db = done_cnt;
    do_start(2);
    wait_done("t6", db, 200);
    check("t6_count", res_n - rb, 2);
    check("t6_row0", res_mem[rb], 23);
    check("t6_row1", res_mem[rb+1], 33);
    check("t6_pop_while_empty", pop_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
